// File: rtl/cpu_register_file_sweep_if.sv
`default_nettype none
// ============================================================================
// cpu_register_file_sweep_if
// Bus bundle for the register file: write, read, reserve and clear-sweep ports.
// Revision: 1.0
// ============================================================================
interface cpu_register_file_sweep_if #(
  parameter int NUMBER_OF_REGISTERS = 256,
  parameter int DATA_WIDTH          = 8
);
  localparam int AW = $clog2(NUMBER_OF_REGISTERS);

  logic                         write_enable_in;
  logic [AW-1:0]                write_register_address_in;
  logic signed [DATA_WIDTH-1:0] write_data_in;
  logic [AW-1:0]                read_register_address1_in;
  logic [AW-1:0]                read_register_address2_in;
  logic signed [DATA_WIDTH-1:0] read_data1_out;
  logic signed [DATA_WIDTH-1:0] read_data2_out;
  logic                         reserve_enable_in;
  logic [AW-1:0]                reserve_address_in;
  logic                         pending1_out;
  logic                         pending2_out;
  logic                         clear_start_in;
  logic                         clear_busy_out;
  logic                         clear_done_out;

  modport master (
    output write_enable_in, write_register_address_in, write_data_in,
    output read_register_address1_in, read_register_address2_in,
    output reserve_enable_in, reserve_address_in, clear_start_in,
    input  read_data1_out, read_data2_out, pending1_out, pending2_out,
    input  clear_busy_out, clear_done_out
  );

  modport slave (
    input  write_enable_in, write_register_address_in, write_data_in,
    input  read_register_address1_in, read_register_address2_in,
    input  reserve_enable_in, reserve_address_in, clear_start_in,
    output read_data1_out, read_data2_out, pending1_out, pending2_out,
    output clear_busy_out, clear_done_out
  );
endinterface
`default_nettype wire

// File: rtl/cpu_register_file_sweep.sv
`default_nettype none
// ============================================================================
// cpu_register_file_sweep
// Two-read/one-write register file with pending bits and a sequential clear.
// Revision: 1.0
// ============================================================================
module cpu_register_file_sweep #(
  parameter int NUMBER_OF_REGISTERS = 256,
  parameter int DATA_WIDTH          = 8,
  parameter int BYPASS              = 1
) (
  input  wire logic               clock_in,
  input  wire logic               reset_in,
  cpu_register_file_sweep_if.slave bus
);
  localparam int             AW     = $clog2(NUMBER_OF_REGISTERS);
  localparam logic [AW-1:0]  c_LAST = AW'(NUMBER_OF_REGISTERS - 1);
  localparam logic [1:0]     c_IDLE  = 2'd0;
  localparam logic [1:0]     c_SWEEP = 2'd1;
  localparam logic [1:0]     c_DONE  = 2'd2;

  logic [NUMBER_OF_REGISTERS-1:0][DATA_WIDTH-1:0] r_regs;
  logic [NUMBER_OF_REGISTERS-1:0]                 r_pending;
  logic [1:0]                                     r_state;
  logic [AW-1:0]                                  r_index;

  logic w_idle;
  logic w_write;
  logic w_reserve;
  logic w_forward;

  assign w_idle    = (r_state == c_IDLE);
  assign w_write   = w_idle && bus.write_enable_in && (bus.write_register_address_in != '0);
  assign w_reserve = w_idle && bus.reserve_enable_in && (bus.reserve_address_in != '0);
  assign w_forward = (BYPASS != 0) && w_idle && bus.write_enable_in;

  // Register 0 is never written, so it stays zero from reset onward.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_regs    <= '0;
      r_pending <= '0;
      r_state   <= c_IDLE;
      r_index   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_write) begin
            r_regs[bus.write_register_address_in]    <= bus.write_data_in;
            r_pending[bus.write_register_address_in] <= 1'b0;
          end
          // Later assignment lets a same-cycle reserve override the write's clear.
          if (w_reserve) begin
            r_pending[bus.reserve_address_in] <= 1'b1;
          end
          if (bus.clear_start_in) begin
            r_state <= c_SWEEP;
            r_index <= AW'(1);
          end
        end
        c_SWEEP: begin
          r_regs[r_index]    <= '0;
          r_pending[r_index] <= 1'b0;
          if (r_index == c_LAST) begin
            r_state <= c_DONE;
          end else begin
            r_index <= r_index + AW'(1);
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
          r_index <= '0;
        end
        default: begin
          r_state <= c_IDLE;
          r_index <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.read_data1_out = $signed(r_regs[bus.read_register_address1_in]);
    if (bus.read_register_address1_in == '0) begin
      bus.read_data1_out = '0;
    end else if (w_forward && (bus.read_register_address1_in == bus.write_register_address_in)) begin
      bus.read_data1_out = bus.write_data_in;
    end
  end

  always_comb begin
    bus.read_data2_out = $signed(r_regs[bus.read_register_address2_in]);
    if (bus.read_register_address2_in == '0) begin
      bus.read_data2_out = '0;
    end else if (w_forward && (bus.read_register_address2_in == bus.write_register_address_in)) begin
      bus.read_data2_out = bus.write_data_in;
    end
  end

  assign bus.pending1_out   = r_pending[bus.read_register_address1_in];
  assign bus.pending2_out   = r_pending[bus.read_register_address2_in];
  assign bus.clear_busy_out = (r_state == c_SWEEP) || (r_state == c_DONE);
  assign bus.clear_done_out = (r_state == c_DONE);
endmodule
`default_nettype wire

// File: tb/tb_cpu_register_file_sweep.sv
`default_nettype none
// ============================================================================
// tb_cpu_register_file_sweep
// Scoreboard bench: BYPASS=1 and BYPASS=0 instances driven in lockstep.
// Revision: 1.0
// ============================================================================
module tb_cpu_register_file_sweep;
  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = $clog2(N);

  logic clock_in = 1'b0;
  logic reset_in;
  always #5 clock_in = ~clock_in;

  cpu_register_file_sweep_if #(.NUMBER_OF_REGISTERS(N), .DATA_WIDTH(DW)) bus_b1 ();
  cpu_register_file_sweep_if #(.NUMBER_OF_REGISTERS(N), .DATA_WIDTH(DW)) bus_b0 ();

  assign bus_b0.write_enable_in           = bus_b1.write_enable_in;
  assign bus_b0.write_register_address_in = bus_b1.write_register_address_in;
  assign bus_b0.write_data_in             = bus_b1.write_data_in;
  assign bus_b0.read_register_address1_in = bus_b1.read_register_address1_in;
  assign bus_b0.read_register_address2_in = bus_b1.read_register_address2_in;
  assign bus_b0.reserve_enable_in         = bus_b1.reserve_enable_in;
  assign bus_b0.reserve_address_in        = bus_b1.reserve_address_in;
  assign bus_b0.clear_start_in            = bus_b1.clear_start_in;

  cpu_register_file_sweep #(.NUMBER_OF_REGISTERS(N), .DATA_WIDTH(DW), .BYPASS(1)) dut_b1 (
    .clock_in(clock_in), .reset_in(reset_in), .bus(bus_b1.slave));
  cpu_register_file_sweep #(.NUMBER_OF_REGISTERS(N), .DATA_WIDTH(DW), .BYPASS(0)) dut_b0 (
    .clock_in(clock_in), .reset_in(reset_in), .bus(bus_b0.slave));

  typedef struct {
    int                   cyc;
    logic signed [DW-1:0] d1, d2, d1n, d2n;
    logic                 p1, p2, busy, done;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference state: a plain array plus "which sweep cycle are we in".
  logic signed [DW-1:0] m_mem [N];
  bit                   m_pend [N];
  bit                   m_busy;
  int                   m_k;

  function automatic logic signed [DW-1:0] m_read(int a, bit byp, bit we, int wa,
                                                  logic signed [DW-1:0] wd);
    if (a == 0) return '0;
    if (byp && we && !m_busy && a == wa) return wd;
    return m_mem[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_k    = 0;
  endtask

  task automatic step(input bit we, input int wa, input logic signed [DW-1:0] wd,
                      input int a1, input int a2, input bit res, input int ra,
                      input bit st, input bit rs);
    exp_t e;
    bus_b1.write_enable_in           = we;
    bus_b1.write_register_address_in = AW'(wa);
    bus_b1.write_data_in             = wd;
    bus_b1.read_register_address1_in = AW'(a1);
    bus_b1.read_register_address2_in = AW'(a2);
    bus_b1.reserve_enable_in         = res;
    bus_b1.reserve_address_in        = AW'(ra);
    bus_b1.clear_start_in            = st;
    reset_in                         = rs;
    e.cyc  = cycle;
    e.d1   = m_read(a1, 1'b1, we, wa, wd);
    e.d2   = m_read(a2, 1'b1, we, wa, wd);
    e.d1n  = m_read(a1, 1'b0, we, wa, wd);
    e.d2n  = m_read(a2, 1'b0, we, wa, wd);
    e.p1   = (a1 != 0) && m_pend[a1];
    e.p2   = (a2 != 0) && m_pend[a2];
    e.busy = m_busy;
    e.done = m_busy && (m_k == N - 1);
    sb.push_back(e);
    @(posedge clock_in);
    if (rs) begin
      m_reset();
    end else if (m_busy) begin
      // Sweep cycle k clears register k+1; the final cycle is the done pulse.
      if (m_k < N - 1) begin
        m_mem[m_k + 1]  = '0;
        m_pend[m_k + 1] = 1'b0;
        m_k++;
      end else begin
        m_busy = 1'b0;
      end
    end else begin
      if (we && wa != 0) begin
        m_mem[wa]  = wd;
        m_pend[wa] = 1'b0;
      end
      if (res && ra != 0) m_pend[ra] = 1'b1;
      if (st) begin
        m_busy = 1'b1;
        m_k    = 0;
      end
    end
    cycle++;
    #1;
  endtask

  task automatic rd(input int a1, input int a2);
    step(1'b0, 0, '0, a1, a2, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input int cyc, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clock_in) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("rd1_byp",  e.cyc, bus_b1.read_data1_out, e.d1);
      chk("rd2_byp",  e.cyc, bus_b1.read_data2_out, e.d2);
      chk("rd1_nobyp", e.cyc, bus_b0.read_data1_out, e.d1n);
      chk("rd2_nobyp", e.cyc, bus_b0.read_data2_out, e.d2n);
      chk("pend1",    e.cyc, DW'(bus_b1.pending1_out), DW'(e.p1));
      chk("pend2",    e.cyc, DW'(bus_b1.pending2_out), DW'(e.p2));
      chk("busy",     e.cyc, DW'(bus_b1.clear_busy_out), DW'(e.busy));
      chk("done",     e.cyc, DW'(bus_b1.clear_done_out), DW'(e.done));
      chk("busy_nobyp", e.cyc, DW'(bus_b0.clear_busy_out), DW'(e.busy));
    end
  end

  initial begin
    bus_b1.write_enable_in           = 1'b0;
    bus_b1.write_register_address_in = '0;
    bus_b1.write_data_in             = '0;
    bus_b1.read_register_address1_in = '0;
    bus_b1.read_register_address2_in = '0;
    bus_b1.reserve_enable_in         = 1'b0;
    bus_b1.reserve_address_in        = '0;
    bus_b1.clear_start_in            = 1'b0;
    reset_in                         = 1'b1;
    m_reset();
    repeat (2) @(posedge clock_in);
    #1;

    // Reset state
    rd(1, 2);
    rd(3, 7);

    // Write and read back, bypass visible only on the BYPASS=1 instance
    step(1'b1, 3, 8'sh5A, 3, 0, 1'b0, 0, 1'b0, 1'b0);
    rd(3, 3);
    step(1'b1, 7, 8'sh11, 1, 7, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 7, -8'sd3, 1, 7, 1'b0, 0, 1'b0, 1'b0);
    rd(7, 7);

    // Register 0 ignores writes and reserves
    step(1'b1, 0, 8'sh7F, 0, 0, 1'b1, 0, 1'b0, 1'b0);
    rd(0, 0);

    // Pending bits: reserve, write clears, reserve beats same-cycle write
    step(1'b0, 0, '0, 5, 0, 1'b1, 5, 1'b0, 1'b0);
    rd(5, 5);
    step(1'b1, 5, 8'sd4, 5, 5, 1'b0, 0, 1'b0, 1'b0);
    rd(5, 5);
    step(1'b1, 5, 8'sd9, 5, 5, 1'b1, 5, 1'b0, 1'b0);
    rd(5, 5);

    // Full sweep with writes/reserves/start attempted while busy
    for (int i = 1; i < N; i++) step(1'b1, i, DW'(i * 17), i, 0, 1'b1, i, 1'b0, 1'b0);
    step(1'b1, 2, 8'sh22, 2, 6, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < N; i++)
      step(1'b1, (i % (N - 1)) + 1, 8'sh3C, i, N - 1 - i, 1'b1, (i % (N - 1)) + 1, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) rd(i, N - 1 - i);

    // Reset aborts a sweep at its third cycle
    for (int i = 1; i < N; i++) step(1'b1, i, DW'(i + 40), i, 0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, '0, 1, 7, 1'b0, 0, 1'b1, 1'b0);
    rd(6, 7);
    rd(6, 7);
    step(1'b1, 4, 8'sh55, 6, 7, 1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) rd(i, N - 1 - i);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)), DW'($urandom),
           int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
           ($urandom_range(0, 3) == 0), int'($urandom_range(0, N - 1)),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 99) == 0));
    end

    @(negedge clock_in);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
